spy_capture_buffer: RTL

SPY_CAPTURE_BUFFER -- requirements
Module: spy_capture_buffer

---
 rtl/spy_capture_buffer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spy_capture_buffer.sv
// spy_capture_buffer
// Trigger-frozen circular capture buffer for a streaming datapath.
// The input stream is forwarded with one register of latency. In parallel,
// every valid word is written into a DEPTH-entry RAM until a freeze
// trigger (plus an optional POST_TRIGGER tail) stops capture. The captured
// window is then played back oldest-to-newest, one word per read request.
//
// Optional feature macro: SPY_EVENT_COUNT_EN
//   defined   -> event_count counts stored words with the metadata MSB set
//   undefined -> event_count is tied to zero and no counter is built

module spy_capture_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 9,
  parameter int POST_TRIGGER = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   write_data,
  input  logic                  write_valid,
  output logic [DATA_WIDTH:0]   output_data,
  output logic                  output_valid,
  input  logic                  freeze,
  input  logic                  unfreeze,
  input  logic                  read_enable,
  output logic [DATA_WIDTH:0]   read_data,
  output logic                  read_valid,
  output logic                  read_last,
  output logic                  frozen,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [15:0]           event_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] POST_INIT  = ADDR_WIDTH'(POST_TRIGGER);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_POST    = 2'd1,
    ST_FROZEN  = 2'd2
  } state_e;

  // Control state
  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q;
  logic [ADDR_WIDTH-1:0]  post_cnt_q;
  logic [ADDR_WIDTH:0]    word_count_q;
  logic [ADDR_WIDTH:0]    remaining_q;

  // Passthrough and playback registers
  logic [DATA_WIDTH:0]    out_data_q;
  logic                   out_valid_q;
  logic                   rd_valid_q;
  logic                   rd_last_q;
  logic [DATA_WIDTH:0]    ram_rd_q;

  // Capture storage
  logic [DATA_WIDTH:0]    mem [DEPTH];

  // Decoded per-cycle actions and next-state values
  logic                   store_en;
  logic                   rd_fire;
  logic [ADDR_WIDTH-1:0]  wr_ptr_d;
  logic [ADDR_WIDTH:0]    word_count_d;
  logic [ADDR_WIDTH-1:0]  oldest_d;

  // Decode write/read actions and the write-side next state shared by all capture states
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    store_en     = (state_q != ST_FROZEN) && write_valid;
    rd_fire      = (state_q == ST_FROZEN) && read_enable &&
                   (remaining_q != '0) && !unfreeze;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    if (store_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (word_count_q != COUNT_FULL) begin
        word_count_d = word_count_q + COUNT_ONE;
      end
    end
    // Once the buffer has filled, the oldest word sits at the write pointer.
    oldest_d = (word_count_d == COUNT_FULL) ? wr_ptr_d : '0;
  end

  // Capture / post-trigger / frozen sequencing, pointers and counters
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_CAPTURE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      word_count_q <= '0;
      remaining_q  <= '0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          wr_ptr_q     <= wr_ptr_d;
          word_count_q <= word_count_d;
          if (freeze) begin
            if (POST_TRIGGER == 0) begin
              state_q     <= ST_FROZEN;
              rd_ptr_q    <= oldest_d;
              remaining_q <= word_count_d;
            end else begin
              state_q    <= ST_POST;
              post_cnt_q <= POST_INIT;
            end
          end
        end

        ST_POST: begin
          wr_ptr_q     <= wr_ptr_d;
          word_count_q <= word_count_d;
          if (write_valid) begin
            post_cnt_q <= post_cnt_q - PTR_ONE;
            if (post_cnt_q == PTR_ONE) begin
              state_q     <= ST_FROZEN;
              rd_ptr_q    <= oldest_d;
              remaining_q <= word_count_d;
            end
          end
        end

        ST_FROZEN: begin
          if (unfreeze) begin
            state_q      <= ST_CAPTURE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            post_cnt_q   <= '0;
            word_count_q <= '0;
            remaining_q  <= '0;
          end else if (rd_fire) begin
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            remaining_q <= remaining_q - COUNT_ONE;
          end
        end

        default: begin
          state_q <= ST_CAPTURE;
        end
      endcase
    end
  end

  // Capture RAM: synchronous write while capturing, synchronous read during playback
  // NOTE: the RAM array is deliberately not reset; clearing it would prevent block-RAM inference,
  // and stale contents are never visible because read_data is qualified by read_valid.
  always_ff @(posedge clock) begin
    if (store_en) begin
      mem[wr_ptr_q] <= write_data;
    end
    if (rd_fire) begin
      ram_rd_q <= mem[rd_ptr_q];
    end
  end

  // Stream passthrough and playback qualifiers, one cycle behind their inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      out_data_q  <= write_data;
      out_valid_q <= write_valid;
      rd_valid_q  <= rd_fire;
      rd_last_q   <= rd_fire && (remaining_q == COUNT_ONE);
    end
  end

`ifdef SPY_EVENT_COUNT_EN
  logic [15:0] event_count_q;

  // Count stored metadata-flagged words, saturating; cleared with the capture
  always_ff @(posedge clock) begin
    if (reset) begin
      event_count_q <= '0;
    end else if ((state_q == ST_FROZEN) && unfreeze) begin
      event_count_q <= '0;
    end else if (store_en && write_data[DATA_WIDTH] && (event_count_q != 16'hFFFF)) begin
      event_count_q <= event_count_q + 16'd1;
    end
  end

  assign event_count = event_count_q;
`else
  assign event_count = 16'd0;
`endif

  assign output_data  = out_data_q;
  assign output_valid = out_valid_q;
  assign read_valid   = rd_valid_q;
  assign read_last    = rd_last_q;
  assign read_data    = rd_valid_q ? ram_rd_q : '0;
  assign frozen       = (state_q == ST_FROZEN);
  assign empty        = (state_q != ST_FROZEN) || (remaining_q == '0);
  assign word_count   = word_count_q;

endmodule
